// File: rtl/gaus_pkg.sv
// Shared constants, state type and the shift-round-saturate helper for the Gaussian datapath.
package gaus_pkg;

  localparam int unsigned GAUS_TAPS  = 7;
  localparam int unsigned GAUS_SHIFT = 8;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned LINE_SUM_W = 16;

  // Width of the argument accepted by round_sat; wide enough for any accumulator plus rounding.
  localparam int unsigned RS_W = 32;

  typedef enum logic {
    StIdle,
    StAcc
  } gaus_state_e;

  typedef struct packed {
    logic             sat;
    logic [PIX_W-1:0] pix;
  } pix_sat_t;

  function automatic int unsigned acc_w(input int unsigned taps);
    return LINE_SUM_W + $clog2(taps);
  endfunction

  localparam int unsigned ACC_W = acc_w(GAUS_TAPS);

  function automatic pix_sat_t round_sat(input logic [RS_W-1:0] s, input int unsigned shift);
    logic [RS_W-1:0] r;
    pix_sat_t        o;
    if (shift == 0) begin
      r = s;
    end else begin
      r = (s + (RS_W'(1) << (shift - 1))) >> shift;
    end
    o.sat = (r > RS_W'((1 << PIX_W) - 1));
    o.pix = o.sat ? '1 : r[PIX_W-1:0];
    return o;
  endfunction

endpackage

// File: rtl/gaus_accum_if.sv
// Line-sum input and pixel output bundle of the Gaussian accumulator.
interface gaus_accum_if;
  import gaus_pkg::*;

  logic                  line_valid;
  logic [LINE_SUM_W-1:0] line_sum;
  logic                  line_first;
  logic                  pix_valid;
  logic [PIX_W-1:0]      pix;
  logic                  pix_eol;
  logic                  err_misalign;
  logic                  err_sat;

  modport master (
    output line_valid, line_sum, line_first,
    input  pix_valid, pix, pix_eol, err_misalign, err_sat
  );

  modport slave (
    input  line_valid, line_sum, line_first,
    output pix_valid, pix, pix_eol, err_misalign, err_sat
  );

endinterface

// File: rtl/gaus_accum.sv
// Accumulates TAPS line sums per pixel group, rounds/normalises by 2^SHIFT, saturates to 8 bits,
// tracks line position and flags framing and saturation errors.
module gaus_accum
  import gaus_pkg::*;
#(
  parameter int unsigned TAPS     = GAUS_TAPS,
  parameter int unsigned SHIFT    = GAUS_SHIFT,
  parameter int unsigned LINE_PIX = 640
) (
  input  logic               clk,
  input  logic               rst,
  gaus_accum_if.slave        bus
);

  localparam int unsigned AccW = acc_w(TAPS);
  localparam int unsigned CntW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned XW   = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;

  gaus_state_e      r_state, w_state_nxt;
  logic [AccW-1:0]  r_acc, w_acc_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic [XW-1:0]    r_xpos, w_xpos_nxt;
  logic             r_pix_valid, w_pix_valid_nxt;
  logic [PIX_W-1:0] r_pix, w_pix_nxt;
  logic             r_pix_eol, w_pix_eol_nxt;
  logic             r_err_mis, w_err_mis_nxt;
  logic             r_err_sat, w_err_sat_nxt;

  logic [AccW:0]    w_sum;
  pix_sat_t         w_rs;
  logic             w_done;

  // acc is held at zero outside a group, so w_sum is also correct for a TAPS==1 completion.
  assign w_sum = (AccW+1)'(r_acc) + (AccW+1)'(bus.line_sum);
  assign w_rs  = round_sat(RS_W'(w_sum), SHIFT);

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_xpos_nxt      = r_xpos;
    w_pix_valid_nxt = 1'b0;
    w_pix_nxt       = r_pix;
    w_pix_eol_nxt   = 1'b0;
    w_err_mis_nxt   = r_err_mis;
    w_err_sat_nxt   = r_err_sat;
    w_done          = 1'b0;

    if (bus.line_valid) begin
      unique case (r_state)
        StIdle: begin
          if (bus.line_first) begin
            if (TAPS == 1) begin
              w_done = 1'b1;
            end else begin
              w_acc_nxt   = AccW'(bus.line_sum);
              w_cnt_nxt   = CntW'(1);
              w_state_nxt = StAcc;
            end
          end else begin
            w_err_mis_nxt = 1'b1;
          end
        end
        StAcc: begin
          if (bus.line_first) begin
            w_err_mis_nxt = 1'b1;
            w_acc_nxt     = AccW'(bus.line_sum);
            w_cnt_nxt     = CntW'(1);
          end else if (r_cnt == CntW'(TAPS - 1)) begin
            w_done = 1'b1;
          end else begin
            w_acc_nxt = w_sum[AccW-1:0];
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      endcase
    end

    if (w_done) begin
      w_pix_valid_nxt = 1'b1;
      w_pix_nxt       = w_rs.pix;
      w_err_sat_nxt   = r_err_sat | w_rs.sat;
      w_pix_eol_nxt   = (r_xpos == XW'(LINE_PIX - 1));
      w_xpos_nxt      = w_pix_eol_nxt ? '0 : r_xpos + 1'b1;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_state_nxt     = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_xpos      <= '0;
      r_pix_valid <= 1'b0;
      r_pix       <= '0;
      r_pix_eol   <= 1'b0;
      r_err_mis   <= 1'b0;
      r_err_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_xpos      <= w_xpos_nxt;
      r_pix_valid <= w_pix_valid_nxt;
      r_pix       <= w_pix_nxt;
      r_pix_eol   <= w_pix_eol_nxt;
      r_err_mis   <= w_err_mis_nxt;
      r_err_sat   <= w_err_sat_nxt;
    end
  end

  assign bus.pix_valid    = r_pix_valid;
  assign bus.pix          = r_pix;
  assign bus.pix_eol      = r_pix_eol;
  assign bus.err_misalign = r_err_mis;
  assign bus.err_sat      = r_err_sat;

endmodule

// File: tb/tb_gaus_accum.sv
// Randomised and directed bench for gaus_accum against a group-level reference model.
module tb_gaus_accum;

  localparam int unsigned TAPS     = 7;
  localparam int unsigned SHIFT    = 8;
  localparam int unsigned LINE_PIX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gaus_accum_if bus ();

  gaus_accum #(
    .TAPS    (TAPS),
    .SHIFT   (SHIFT),
    .LINE_PIX(LINE_PIX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples of the open group, pixel count and expected outputs.
  int unsigned grp[$];
  int unsigned n_pix;
  bit          m_valid, m_eol, m_mis, m_sat;
  int unsigned m_pix;

  int unsigned obs_pix[$];
  bit          obs_eol[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    grp.delete();
    n_pix   = 0;
    m_valid = 0;
    m_eol   = 0;
    m_mis   = 0;
    m_sat   = 0;
    m_pix   = 0;
  endtask

  task automatic model_sample(input bit v, input bit f, input int unsigned s);
    int unsigned total, r;
    m_valid = 0;
    m_eol   = 0;
    if (!v) return;
    if (f) begin
      if (grp.size() > 0) m_mis = 1;
      grp.delete();
      grp.push_back(s);
    end else if (grp.size() == 0) begin
      m_mis = 1;
    end else begin
      grp.push_back(s);
    end
    if (grp.size() == TAPS) begin
      total = 0;
      foreach (grp[i]) total += grp[i];
      r = (total + (1 << (SHIFT - 1))) >> SHIFT;
      if (r > 255) begin
        m_sat = 1;
        m_pix = 255;
      end else begin
        m_pix = r;
      end
      m_valid = 1;
      m_eol   = ((n_pix % LINE_PIX) == LINE_PIX - 1);
      n_pix++;
      grp.delete();
    end
  endtask

  task automatic check_outputs();
    check("pix_valid", 32'(bus.pix_valid), 32'(m_valid));
    check("pix", 32'(bus.pix), m_pix);
    if (m_valid) check("pix_eol", 32'(bus.pix_eol), 32'(m_eol));
    check("err_misalign", 32'(bus.err_misalign), 32'(m_mis));
    check("err_sat", 32'(bus.err_sat), 32'(m_sat));
  endtask

  // One clock: drive after negedge, model the rising edge, check at the next negedge.
  task automatic step(input bit v, input bit f, input int unsigned s);
    bus.line_valid = v;
    bus.line_first = f;
    bus.line_sum   = 16'(s);
    @(posedge clk);
    model_sample(v, f, s);
    @(negedge clk);
    check_outputs();
    if (bus.pix_valid) begin
      obs_pix.push_back(32'(bus.pix));
      obs_eol.push_back(bus.pix_eol);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 65535));
  endtask

  task automatic group(input int unsigned s, input int unsigned max_gap);
    for (int i = 0; i < TAPS; i++) begin
      step(1, i == 0, s);
      if (max_gap > 0 && i < TAPS - 1) idle($urandom_range(0, max_gap));
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst pix_valid", 32'(bus.pix_valid), 0);
    check("rst pix", 32'(bus.pix), 0);
    check("rst pix_eol", 32'(bus.pix_eol), 0);
    check("rst err_misalign", 32'(bus.err_misalign), 0);
    check("rst err_sat", 32'(bus.err_sat), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned base;
    bus.line_valid = 0;
    bus.line_first = 0;
    bus.line_sum   = 0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Back-to-back groups
    base = obs_pix.size();
    group(256, 0);
    group(384, 0);
    check("bb count", obs_pix.size() - base, 2);
    if (obs_pix.size() >= base + 2) begin
      check("bb pix0", obs_pix[base], 7);
      check("bb pix1", obs_pix[base+1], 11);
    end

    // Saturation
    group(65535, 0);
    check("sat pix", 32'(bus.pix), 255);
    check("sat flag", 32'(bus.err_sat), 1);

    // Misalignment: partial group restarted by a new line_first
    base = obs_pix.size();
    for (int i = 0; i < 3; i++) step(1, i == 0, 100);
    group(100, 0);
    check("mis count", obs_pix.size() - base, 1);
    check("mis pix", 32'(bus.pix), 3);
    check("mis flag", 32'(bus.err_misalign), 1);

    // Stray sample in idle after reset
    apply_reset();
    base = obs_pix.size();
    step(1, 0, 500);
    idle(2);
    check("stray count", obs_pix.size() - base, 0);
    check("stray flag", 32'(bus.err_misalign), 1);

    // Gaps and line wrap
    apply_reset();
    base = obs_pix.size();
    for (int g = 0; g < 5; g++) begin
      group($urandom_range(0, 9000), 3);
      idle($urandom_range(0, 2));
    end
    check("wrap count", obs_pix.size() - base, 5);
    if (obs_pix.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) check("wrap eol", 32'(obs_eol[base+i]), (i == 3) ? 1 : 0);
    end

    // Reset in the middle of a group, flags set beforehand
    group(65535, 0);
    step(1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, i == 0, 256);
    apply_reset();
    base = obs_pix.size();
    group(256, 0);
    idle(2);
    check("rst-mid count", obs_pix.size() - base, 1);
    check("rst-mid pix", 32'(bus.pix), 7);

    // Random traffic: gaps, restarts, strays, full-range sums
    for (int g = 0; g < 300; g++) begin
      int unsigned kind, n;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        step(1, 0, $urandom_range(0, 65535));
      end else if (kind == 1) begin
        n = $urandom_range(1, TAPS - 1);
        for (int i = 0; i < n; i++) step(1, i == 0, $urandom_range(0, 65535));
      end else begin
        for (int i = 0; i < TAPS; i++) begin
          step(1, i == 0, (kind == 2) ? $urandom_range(30000, 65535) : $urandom_range(0, 12000));
          if (kind > 6) idle($urandom_range(0, 2));
        end
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
